// File: rtl/dcache_bus_seq_if.sv
// Cache-side request/response and AHB master signals of the
// line-transfer sequencer, bundled for master (DUT) and slave (env).
interface dcache_bus_seq_if #(
  parameter int PA_BITS = 56,
  parameter int LINELEN = 512,
  parameter int AHBW    = 64
);
  localparam int BL = $clog2(LINELEN / AHBW);

  logic [1:0]         CacheBusRW;
  logic [PA_BITS-1:0] CacheBusAdr;
  logic               FlushStage;
  logic               Stall;
  logic [AHBW-1:0]    CacheWriteData;
  logic               HREADY;
  logic [AHBW-1:0]    HRDATA;
  logic [PA_BITS-1:0] HADDR;
  logic               HWRITE;
  logic [1:0]         HTRANS;
  logic [2:0]         HBURST;
  logic [AHBW-1:0]    HWDATA;
  logic [LINELEN-1:0] FetchBuffer;
  logic [BL-1:0]      BeatCount;
  logic               SelBusBeat;
  logic               CacheBusAck;
  logic               BusCommitted;

  modport master (
    input  CacheBusRW, CacheBusAdr, FlushStage, Stall,
    input  CacheWriteData, HREADY, HRDATA,
    output HADDR, HWRITE, HTRANS, HBURST, HWDATA,
    output FetchBuffer, BeatCount, SelBusBeat,
    output CacheBusAck, BusCommitted
  );

  modport slave (
    output CacheBusRW, CacheBusAdr, FlushStage, Stall,
    output CacheWriteData, HREADY, HRDATA,
    input  HADDR, HWRITE, HTRANS, HBURST, HWDATA,
    input  FetchBuffer, BeatCount, SelBusBeat,
    input  CacheBusAck, BusCommitted
  );
endinterface

// File: rtl/dcache_bus_seq.sv
// D-cache line fetch/writeback sequencer driving pipelined
// AHB INCR bursts; one line per request.
module dcache_bus_seq #(
  parameter int PA_BITS = 56,
  parameter int LINELEN = 512,
  parameter int AHBW    = 64
) (
  input logic              clk,
  input logic              reset,
  dcache_bus_seq_if.master bus
);
  localparam int BEATS = LINELEN / AHBW;
  localparam int BL    = $clog2(BEATS);
  localparam int CW    = BL + 1;

  localparam logic [2:0] BURST =
    (BEATS == 4) ? 3'b011 :
    (BEATS == 8) ? 3'b101 : 3'b111;

  localparam logic [CW-1:0] ALL  = CW'(BEATS);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [PA_BITS-1:0] STEP = PA_BITS'(AHBW / 8);

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    IDLE, ADR, DATA, DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      acnt_q, acnt_d;
  logic [CW-1:0]      dcnt_q, dcnt_d;
  logic [PA_BITS-1:0] adr_q, adr_d;
  logic               wr_q, wr_d;
  logic [AHBW-1:0]    hwdata_q, hwdata_d;
  logic [LINELEN-1:0] fbuf_q, fbuf_d;

  logic       aphase;
  logic       dphase;
  logic       ack;
  logic [1:0] htrans;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      acnt_q   <= '0;
      dcnt_q   <= '0;
      adr_q    <= '0;
      wr_q     <= 1'b0;
      hwdata_q <= '0;
      fbuf_q   <= '0;
    end else begin
      state_q  <= state_d;
      acnt_q   <= acnt_d;
      dcnt_q   <= dcnt_d;
      adr_q    <= adr_d;
      wr_q     <= wr_d;
      hwdata_q <= hwdata_d;
      fbuf_q   <= fbuf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acnt_d   = acnt_q;
    dcnt_d   = dcnt_q;
    adr_d    = adr_q;
    wr_d     = wr_q;
    hwdata_d = hwdata_q;
    fbuf_d   = fbuf_q;
    aphase   = 1'b0;
    dphase   = 1'b0;
    ack      = 1'b0;
    htrans   = T_IDLE;

    unique case (state_q)
      IDLE: begin
        if (|bus.CacheBusRW && !bus.FlushStage) begin
          state_d = ADR;
          adr_d   = bus.CacheBusAdr;
          wr_d    = bus.CacheBusRW[0];
        end
      end
      ADR: aphase = 1'b1;
      DATA: begin
        aphase = (acnt_q != ALL);
        dphase = 1'b1;
      end
      DONE: begin
        if (!bus.Stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (aphase) htrans = (acnt_q == '0) ? T_NONSEQ : T_SEQ;

    // Nothing moves on a wait-stated edge; address leads data by one.
    if (bus.HREADY) begin
      if (aphase) begin
        acnt_d = acnt_q + ONE;
        if (wr_q) hwdata_d = bus.CacheWriteData;
      end
      if (dphase) begin
        dcnt_d = dcnt_q + ONE;
        if (!wr_q) fbuf_d[dcnt_q[BL-1:0]*AHBW +: AHBW] = bus.HRDATA;
      end
      if (state_q == ADR) state_d = DATA;
      if (dphase && dcnt_q == LAST) begin
        ack     = 1'b1;
        state_d = DONE;
        acnt_d  = '0;
        dcnt_d  = '0;
      end
    end
  end

  logic busy;
  logic on_bus;

  assign busy   = (state_q != IDLE);
  assign on_bus = (state_q == ADR) || (state_q == DATA);

  assign bus.HADDR        = adr_q + PA_BITS'(acnt_q) * STEP;
  assign bus.HWRITE       = wr_q & on_bus;
  assign bus.HTRANS       = htrans;
  assign bus.HBURST       = (htrans != T_IDLE) ? BURST : 3'b000;
  assign bus.HWDATA       = hwdata_q;
  assign bus.FetchBuffer  = fbuf_q;
  assign bus.BeatCount    = wr_q ? acnt_q[BL-1:0] : dcnt_q[BL-1:0];
  assign bus.SelBusBeat   = busy;
  assign bus.CacheBusAck  = ack;
  assign bus.BusCommitted = busy;
endmodule

// File: tb/tb_dcache_bus_seq.sv
// Randomized bench for dcache_bus_seq: acts as cache and AHB
// slave, checks every cycle against a beat-level burst model.
module tb_dcache_bus_seq;
  localparam int PA = 56;
  localparam int LL = 512;
  localparam int W  = 64;
  localparam int NB = LL / W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [LL-1:0] wline;
  logic [LL-1:0] fb_m;

  dcache_bus_seq_if #(.PA_BITS(PA), .LINELEN(LL), .AHBW(W)) bus ();

  dcache_bus_seq #(.PA_BITS(PA), .LINELEN(LL), .AHBW(W)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.CacheWriteData = wline[bus.BeatCount*W +: W];

  task automatic chk(input string tag, input logic [LL-1:0] got,
                     input logic [LL-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_htrans"}, LL'(bus.HTRANS), '0);
    chk({tag, "_hwrite"}, LL'(bus.HWRITE), '0);
    chk({tag, "_hburst"}, LL'(bus.HBURST), '0);
    chk({tag, "_haddr"}, LL'(bus.HADDR), '0);
    chk({tag, "_hwdata"}, LL'(bus.HWDATA), '0);
    chk({tag, "_beat"}, LL'(bus.BeatCount), '0);
    chk({tag, "_sel"}, LL'(bus.SelBusBeat), '0);
    chk({tag, "_ack"}, LL'(bus.CacheBusAck), '0);
    chk({tag, "_commit"}, LL'(bus.BusCommitted), '0);
    chk({tag, "_fbuf"}, bus.FetchBuffer, '0);
  endtask

  function automatic logic [PA-1:0] rnd_line();
    logic [PA-1:0] a;
    a = PA'({$urandom, $urandom});
    a[5:0] = '0;
    return a;
  endfunction

  task automatic rnd_wline();
    for (int k = 0; k < NB; k++) wline[k*W +: W] = {$urandom, $urandom};
  endtask

  // Starts at a negedge; s0/sl give a forced wait-state window
  // (cycle 1 = ADR), abort_at asserts reset in that cycle.
  task automatic run_txn(input logic [1:0] rw, input logic [PA-1:0] adr,
                         input bit idx_data, input bit rnd_rdy,
                         input int s0, input int sl,
                         input int dstall, input int abort_at);
    logic          wr;
    int            cyc, na, nd, zeros;
    bit            aact, dact, rdy, acke;
    logic [W-1:0]  rd;
    logic [PA-1:0] ea;
    wr = rw[0];
    cyc = 1; na = 0; nd = 0; zeros = 0;
    bus.CacheBusRW  = rw;
    bus.CacheBusAdr = adr;
    bus.FlushStage  = 1'b0;
    bus.Stall       = (dstall > 0);
    bus.HREADY      = 1'b1;
    @(negedge clk);
    forever begin
      if (cyc == abort_at) begin
        #2 rst_n = 1'b0;
        #1 chk_reset("abort");
        fb_m = '0;
        return;
      end
      aact = (na < NB);
      dact = (nd < na);
      rdy  = !(cyc >= s0 && cyc < s0 + sl) &&
             (!rnd_rdy || $urandom_range(3) != 0);
      rd   = idx_data ? W'(nd) : {$urandom, $urandom};
      bus.HREADY      = rdy;
      bus.HRDATA      = rd;
      bus.CacheBusRW  = 2'($urandom);
      bus.CacheBusAdr = PA'({$urandom, $urandom});
      bus.FlushStage  = 1'($urandom);
      #1;
      acke = dact && nd == NB - 1 && rdy;
      ea   = adr + PA'(na * (W / 8));
      chk("htrans", LL'(bus.HTRANS), LL'(aact ? (na == 0 ? 2 : 3) : 0));
      if (aact) begin
        chk("haddr", LL'(bus.HADDR), LL'(ea));
        chk("hburst", LL'(bus.HBURST), LL'(3'b101));
        chk("hwrite", LL'(bus.HWRITE), LL'(wr));
        if (wr) chk("wbeat", LL'(bus.BeatCount), LL'(na));
      end
      if (dact && wr) chk("hwdata", LL'(bus.HWDATA), LL'(wline[nd*W +: W]));
      if (dact && !wr) chk("rbeat", LL'(bus.BeatCount), LL'(nd));
      chk("commit", LL'(bus.BusCommitted), LL'(1));
      chk("sel", LL'(bus.SelBusBeat), LL'(1));
      chk("ack", LL'(bus.CacheBusAck), LL'(acke));
      if (!rdy) zeros++;
      if (rdy && dact && !wr) fb_m[nd*W +: W] = rd;
      if (rdy) begin
        if (dact) nd++;
        if (aact) na++;
      end
      if (acke || cyc > 400) break;
      @(negedge clk);
      cyc++;
    end
    chk("latency", LL'(cyc), LL'(NB + 1 + zeros));
    @(negedge clk);
    chk("done_commit", LL'(bus.BusCommitted), LL'(1));
    chk("done_htrans", LL'(bus.HTRANS), '0);
    chk("done_ack", LL'(bus.CacheBusAck), '0);
    chk("fbuf", bus.FetchBuffer, fb_m);
    for (int i = 0; i < dstall; i++) begin
      bus.CacheBusRW = 2'($urandom_range(1, 3));
      @(negedge clk);
      chk("stall_commit", LL'(bus.BusCommitted), LL'(1));
      chk("stall_htrans", LL'(bus.HTRANS), '0);
      chk("stall_ack", LL'(bus.CacheBusAck), '0);
    end
    bus.CacheBusRW = 2'b00;
    bus.Stall      = 1'b0;
    bus.FlushStage = 1'b0;
    @(negedge clk);
    chk("idle_commit", LL'(bus.BusCommitted), '0);
    chk("idle_sel", LL'(bus.SelBusBeat), '0);
    chk("idle_htrans", LL'(bus.HTRANS), '0);
  endtask

  initial begin
    bus.CacheBusRW  = 2'b00;
    bus.CacheBusAdr = '0;
    bus.FlushStage  = 1'b0;
    bus.Stall       = 1'b0;
    bus.HREADY      = 1'b1;
    bus.HRDATA      = '0;
    wline           = '0;
    fb_m            = '0;
    repeat (3) @(negedge clk);
    chk_reset("por");
    rst_n = 1'b1;

    run_txn(2'b10, 56'h80001000, 1'b1, 1'b0, 0, 0, 0, 0);

    for (int k = 0; k < NB; k++) wline[k*W +: W] = W'(8'hA0 + k);
    run_txn(2'b01, 56'h80002000, 1'b0, 1'b0, 0, 0, 0, 0);

    run_txn(2'b10, 56'h80003040, 1'b0, 1'b0, 4, 3, 0, 0);
    rnd_wline();
    run_txn(2'b01, 56'h80004080, 1'b0, 1'b0, 4, 3, 0, 0);

    bus.CacheBusRW = 2'b10;
    bus.FlushStage = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("flush_htrans", LL'(bus.HTRANS), '0);
      chk("flush_commit", LL'(bus.BusCommitted), '0);
      chk("flush_ack", LL'(bus.CacheBusAck), '0);
    end
    bus.CacheBusRW = 2'b00;
    bus.FlushStage = 1'b0;

    rnd_wline();
    run_txn(2'b11, rnd_line(), 1'b0, 1'b0, 0, 0, 0, 0);

    run_txn(2'b10, rnd_line(), 1'b0, 1'b0, 0, 0, 4, 0);

    run_txn(2'b10, 56'h80005000, 1'b1, 1'b0, 0, 0, 0, 6);
    @(negedge clk);
    chk_reset("hold");
    rst_n = 1'b1;
    run_txn(2'b10, 56'h80005000, 1'b0, 1'b0, 0, 0, 0, 0);

    repeat (24) begin
      rnd_wline();
      run_txn(2'($urandom_range(1, 3)), rnd_line(), 1'b0, 1'b1,
              0, 0, $urandom_range(0, 3), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
